mem_nack_retry_buffer: RTL and testbench

- Sits between the xbarCoreL2 memory port and the sramL2_64K L2.
- Holds every request accepted from the crossbar until the L2 completes it.
- When the L2 answers with a nack, the block re-issues the held request transparently.
- Non-nacked responses are forwarded upstream, so the crossbar never sees a nack.

---
 rtl/mem_nack_retry_buffer.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_nack_retry_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_nack_retry_buffer.sv
// mem_nack_retry_buffer
//   Retry buffer between the crossbar memory port and the L2. It holds every
//   accepted request in a slot until the L2 completes it. A nacked request is
//   re-queued and re-issued without the crossbar seeing the nack. Requests
//   issue in accept order through a FIFO of slot indices.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   in_req_*            : request from the crossbar (val/rdy handshake)
//   in_resp_*           : non-nacked response beats to the crossbar
//   l2_req_*            : request to the L2 (val/rdy handshake)
//   l2_resp_*           : response beats from the L2, which may carry a nack
//   err_unmatched       : sticky flag, set when an L2 response matches no slot
//
// Optional build macro MEM_RETRY_STATS_EN adds two outputs:
//   nack_count [31:0]   : saturating count of accepted nacks
//   max_retries [7:0]   : largest run of consecutive nacks on one request
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_L2TAG_BITS
`define MEM_L2TAG_BITS 8
`endif

module mem_nack_retry_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ADDR_BITS = `MEM_ADDR_BITS,
   parameter int unsigned DATA_BITS = `MEM_DATA_BITS,
   parameter int unsigned TAG_BITS  = `MEM_L2TAG_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_req_val,
   output logic                 in_req_rdy,
   input  logic [1:0]           in_req_rw,
   input  logic [ADDR_BITS-1:0] in_req_addr,
   input  logic [DATA_BITS-1:0] in_req_data,
   input  logic [TAG_BITS-1:0]  in_req_tag,
   output logic                 in_resp_val,
   output logic                 in_resp_nack,
   output logic [DATA_BITS-1:0] in_resp_data,
   output logic [TAG_BITS-1:0]  in_resp_tag,
   output logic                 l2_req_val,
   input  logic                 l2_req_rdy,
   output logic [1:0]           l2_req_rw,
   output logic [ADDR_BITS-1:0] l2_req_addr,
   output logic [DATA_BITS-1:0] l2_req_data,
   output logic [TAG_BITS-1:0]  l2_req_tag,
   input  logic                 l2_resp_val,
   input  logic                 l2_resp_nack,
   input  logic [DATA_BITS-1:0] l2_resp_data,
   input  logic [TAG_BITS-1:0]  l2_resp_tag,
   output logic                 err_unmatched
`ifdef MEM_RETRY_STATS_EN
   ,
   output logic [31:0]          nack_count,
   output logic [7:0]           max_retries
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   typedef logic [IDX_W-1:0] idx_t;

   logic [DEPTH-1:0]     alloc_q, alloc_d;
   logic [1:0]           rw_q   [DEPTH];
   logic [1:0]           rw_d   [DEPTH];
   logic [ADDR_BITS-1:0] addr_q [DEPTH];
   logic [ADDR_BITS-1:0] addr_d [DEPTH];
   logic [DATA_BITS-1:0] data_q [DEPTH];
   logic [DATA_BITS-1:0] data_d [DEPTH];
   logic [TAG_BITS-1:0]  tag_q  [DEPTH];
   logic [TAG_BITS-1:0]  tag_d  [DEPTH];
   logic [1:0]           beat_q [DEPTH];
   logic [1:0]           beat_d [DEPTH];

   idx_t                 fifo_q [DEPTH];
   idx_t                 fifo_d [DEPTH];
   idx_t                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 rdy_en_q, rdy_en_d;
   logic                 err_q, err_d;

   logic                 free_found, tag_busy, resp_hit;
   idx_t                 free_idx, resp_idx, head_idx;
   logic                 acc, pop, nack_push, ack_hit;
   logic [1:0]           push_n;

   // Slot lookups use registered state only, so a slot freed this cycle
   // becomes allocatable on the next one.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      tag_busy   = 1'b0;
      resp_hit   = 1'b0;
      resp_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!alloc_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = idx_t'(i);
         end
         if (alloc_q[i] && (tag_q[i] == in_req_tag)) tag_busy = 1'b1;
         if (alloc_q[i] && (tag_q[i] == l2_resp_tag)) begin
            resp_hit = 1'b1;
            resp_idx = idx_t'(i);
         end
      end
   end

   // rdy_en_q keeps in_req_rdy low while reset is held and until the first edge after release.
   assign in_req_rdy   = rdy_en_q & free_found & ~tag_busy;
   assign head_idx     = fifo_q[rd_ptr_q];
   assign l2_req_val   = (cnt_q != '0);
   assign l2_req_rw    = rw_q[head_idx];
   assign l2_req_addr  = addr_q[head_idx];
   assign l2_req_data  = data_q[head_idx];
   assign l2_req_tag   = tag_q[head_idx];

   assign in_resp_val  = l2_resp_val & resp_hit & ~l2_resp_nack;
   assign in_resp_nack = 1'b0;
   assign in_resp_data = l2_resp_data;
   assign in_resp_tag  = l2_resp_tag;
   assign err_unmatched = err_q;

   assign acc       = in_req_val & in_req_rdy;
   assign pop       = l2_req_val & l2_req_rdy;
   assign nack_push = l2_resp_val & resp_hit & l2_resp_nack;
   assign ack_hit   = l2_resp_val & resp_hit & ~l2_resp_nack;
   assign push_n    = {1'b0, nack_push} + {1'b0, acc};

   always_comb begin
      alloc_d  = alloc_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tag_d    = tag_q;
      beat_d   = beat_q;
      fifo_d   = fifo_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rdy_en_d = 1'b1;
      err_d    = err_q | (l2_resp_val & ~resp_hit);

      if (ack_hit) begin
         beat_d[resp_idx] = beat_q[resp_idx] + 2'd1;
         if ((rw_q[resp_idx] != 2'b00) || (beat_q[resp_idx] == 2'd3))
            alloc_d[resp_idx] = 1'b0;
      end

      // The nack entry takes the write slot first so a retry lands ahead of
      // a request accepted in the same cycle.
      if (nack_push) begin
         beat_d[resp_idx] = 2'd0;
         fifo_d[wr_ptr_d] = resp_idx;
         wr_ptr_d         = wr_ptr_d + idx_t'(1);
      end

      if (acc) begin
         alloc_d[free_idx] = 1'b1;
         rw_d[free_idx]    = in_req_rw;
         addr_d[free_idx]  = in_req_addr;
         data_d[free_idx]  = in_req_data;
         tag_d[free_idx]   = in_req_tag;
         beat_d[free_idx]  = 2'd0;
         fifo_d[wr_ptr_d]  = free_idx;
         wr_ptr_d          = wr_ptr_d + idx_t'(1);
      end

      if (pop) rd_ptr_d = rd_ptr_q + idx_t'(1);
      cnt_d = cnt_q + CNT_W'(push_n) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alloc_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         rdy_en_q <= 1'b0;
         err_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rw_q[i]   <= '0;
            addr_q[i] <= '0;
            data_q[i] <= '0;
            tag_q[i]  <= '0;
            beat_q[i] <= '0;
            fifo_q[i] <= '0;
         end
      end else begin
         alloc_q  <= alloc_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         tag_q    <= tag_d;
         beat_q   <= beat_d;
         fifo_q   <= fifo_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         rdy_en_q <= rdy_en_d;
         err_q    <= err_d;
      end
   end

`ifdef MEM_RETRY_STATS_EN
   logic [7:0]  retry_q [DEPTH];
   logic [7:0]  retry_d [DEPTH];
   logic [31:0] nack_count_q, nack_count_d;
   logic [7:0]  max_retries_q, max_retries_d;
   logic [7:0]  retry_new;

   // Per-slot run of consecutive nacks; a request completes on its first ack,
   // so the run only needs clearing when the slot is re-allocated.
   always_comb begin
      retry_d       = retry_q;
      nack_count_d  = nack_count_q;
      max_retries_d = max_retries_q;
      retry_new     = retry_q[resp_idx];
      if (nack_push) begin
         if (nack_count_q != '1) nack_count_d = nack_count_q + 32'd1;
         if (retry_q[resp_idx] != '1) retry_new = retry_q[resp_idx] + 8'd1;
         retry_d[resp_idx] = retry_new;
         if (retry_new > max_retries_q) max_retries_d = retry_new;
      end
      if (acc) retry_d[free_idx] = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nack_count_q  <= '0;
         max_retries_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) retry_q[i] <= '0;
      end else begin
         nack_count_q  <= nack_count_d;
         max_retries_q <= max_retries_d;
         retry_q       <= retry_d;
      end
   end

   assign nack_count  = nack_count_q;
   assign max_retries = max_retries_q;
`endif

endmodule

// File: tb/tb_mem_nack_retry_buffer.sv
// tb_mem_nack_retry_buffer
//   Directed scoreboard bench for mem_nack_retry_buffer. Stimulus pushes the
//   expected L2 requests and upstream responses into queues; a monitor pops
//   and compares them whenever the DUT presents a transfer.
module tb_mem_nack_retry_buffer;

   typedef struct packed {
      logic [1:0]  rw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  tag;
   } req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  tag;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_req_val, in_req_rdy;
   logic [1:0]  in_req_rw;
   logic [31:0] in_req_addr, in_req_data;
   logic [7:0]  in_req_tag;
   logic        in_resp_val, in_resp_nack;
   logic [31:0] in_resp_data;
   logic [7:0]  in_resp_tag;
   logic        l2_req_val, l2_req_rdy;
   logic [1:0]  l2_req_rw;
   logic [31:0] l2_req_addr, l2_req_data;
   logic [7:0]  l2_req_tag;
   logic        l2_resp_val, l2_resp_nack;
   logic [31:0] l2_resp_data;
   logic [7:0]  l2_resp_tag;
   logic        err_unmatched;
`ifdef MEM_RETRY_STATS_EN
   logic [31:0] nack_count;
   logic [7:0]  max_retries;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;
   req_t        exp_req_q[$];
   resp_t       exp_resp_q[$];

   always #5 clk = ~clk;

   mem_nack_retry_buffer #(
      .DEPTH(4), .ADDR_BITS(32), .DATA_BITS(32), .TAG_BITS(8)
   ) dut (
      .clk(clk), .reset(reset),
      .in_req_val(in_req_val), .in_req_rdy(in_req_rdy), .in_req_rw(in_req_rw),
      .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
      .in_resp_val(in_resp_val), .in_resp_nack(in_resp_nack),
      .in_resp_data(in_resp_data), .in_resp_tag(in_resp_tag),
      .l2_req_val(l2_req_val), .l2_req_rdy(l2_req_rdy), .l2_req_rw(l2_req_rw),
      .l2_req_addr(l2_req_addr), .l2_req_data(l2_req_data), .l2_req_tag(l2_req_tag),
      .l2_resp_val(l2_resp_val), .l2_resp_nack(l2_resp_nack),
      .l2_resp_data(l2_resp_data), .l2_resp_tag(l2_resp_tag),
      .err_unmatched(err_unmatched)
`ifdef MEM_RETRY_STATS_EN
      , .nack_count(nack_count), .max_retries(max_retries)
`endif
   );

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      req_t  er;
      resp_t es;
      forever begin
         @(negedge clk);
         if (l2_req_val && l2_req_rdy) begin
            checks++;
            if (exp_req_q.size() == 0) begin
               errors++;
               $display("FAIL l2_req_unexpected: got tag=%0d rw=%0d, none expected", l2_req_tag, l2_req_rw);
            end else begin
               er = exp_req_q.pop_front();
               if ({l2_req_rw, l2_req_addr, l2_req_data, l2_req_tag} !== er) begin
                  errors++;
                  $display("FAIL l2_req: got rw=%0d addr=%h data=%h tag=%0d, expected rw=%0d addr=%h data=%h tag=%0d",
                           l2_req_rw, l2_req_addr, l2_req_data, l2_req_tag, er.rw, er.addr, er.data, er.tag);
               end
            end
         end
         if (in_resp_val) begin
            checks++;
            if (exp_resp_q.size() == 0) begin
               errors++;
               $display("FAIL in_resp_unexpected: got tag=%0d data=%h, none expected", in_resp_tag, in_resp_data);
            end else begin
               es = exp_resp_q.pop_front();
               if ({in_resp_data, in_resp_tag} !== es || in_resp_nack !== 1'b0) begin
                  errors++;
                  $display("FAIL in_resp: got tag=%0d data=%h nack=%0b, expected tag=%0d data=%h nack=0",
                           in_resp_tag, in_resp_data, in_resp_nack, es.tag, es.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic send_req(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] t);
      bit ok = 1'b0;
      in_req_rw = rw; in_req_addr = a; in_req_data = d; in_req_tag = t;
      in_req_val = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = in_req_rdy;
         @(posedge clk); #1;
      end
      in_req_val = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_tag%0d: in_req_rdy stayed 0, expected 1 within 40 cycles", t);
      end else begin
         exp_req_q.push_back('{rw: rw, addr: a, data: d, tag: t});
      end
   endtask

   task automatic l2_respond(input logic nack, input logic [31:0] d, input logic [7:0] t,
                             input bit fwd);
      l2_resp_val = 1'b1; l2_resp_nack = nack; l2_resp_data = d; l2_resp_tag = t;
      if (fwd) exp_resp_q.push_back('{data: d, tag: t});
      @(posedge clk); #1;
      l2_resp_val = 1'b0; l2_resp_nack = 1'b0;
   endtask

   task automatic wait_issue(input string name);
      for (int n = 0; n < 50 && exp_req_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      chk(name, exp_req_q.size(), 0);
   endtask

   initial begin
      reset = 1'b0;
      in_req_val = 1'b0; in_req_rw = '0; in_req_addr = '0; in_req_data = '0; in_req_tag = '0;
      l2_req_rdy = 1'b0;
      l2_resp_val = 1'b0; l2_resp_nack = 1'b0; l2_resp_data = '0; l2_resp_tag = '0;

      // Reset state
      @(negedge clk);
      chk("rst_in_req_rdy", in_req_rdy, 0);
      chk("rst_l2_req_val", l2_req_val, 0);
      chk("rst_in_resp_val", in_resp_val, 0);
      chk("rst_err_unmatched", err_unmatched, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Single store, tag 3, acked two cycles after issue
      l2_req_rdy = 1'b1;
      send_req(2'b01, 32'h0000_1000, 32'hDEAD_BEEF, 8'd3);
      wait_issue("store_issue");
      repeat (2) begin @(posedge clk); #1; end
      l2_respond(1'b0, 32'h1234_5678, 8'd3, 1'b1);
      @(negedge clk);
      chk("store_slot_freed_rdy", in_req_rdy, 1);
      @(posedge clk); #1;

      // 4-beat load, tag 5
      send_req(2'b00, 32'h0000_2040, 32'h0, 8'd5);
      wait_issue("load4_issue");
      l2_respond(1'b0, 32'hA000_0000, 8'd5, 1'b1);
      l2_respond(1'b0, 32'hA000_0001, 8'd5, 1'b1);
      l2_respond(1'b0, 32'hA000_0002, 8'd5, 1'b1);
      in_req_tag = 8'd5;
      @(negedge clk);
      chk("load4_tag5_stalled", in_req_rdy, 0);
      @(posedge clk); #1;
      l2_respond(1'b0, 32'hA000_0003, 8'd5, 1'b1);
      @(negedge clk);
      chk("load4_tag5_released", in_req_rdy, 1);
      @(posedge clk); #1;

      // 1-beat load, tag 7, nacked twice then acked
      send_req(2'b10, 32'h0000_3000, 32'h0, 8'd7);
      wait_issue("nack_issue0");
      exp_req_q.push_back('{rw: 2'b10, addr: 32'h0000_3000, data: 32'h0, tag: 8'd7});
      l2_respond(1'b1, 32'hFFFF_FFFF, 8'd7, 1'b0);
      wait_issue("nack_issue1");
      exp_req_q.push_back('{rw: 2'b10, addr: 32'h0000_3000, data: 32'h0, tag: 8'd7});
      l2_respond(1'b1, 32'hFFFF_FFFF, 8'd7, 1'b0);
      wait_issue("nack_issue2");
      l2_respond(1'b0, 32'h7777_0007, 8'd7, 1'b1);
`ifdef MEM_RETRY_STATS_EN
      @(negedge clk);
      chk("nack_count_2", nack_count, 2);
      chk("max_retries_2", max_retries, 2);
      @(posedge clk); #1;
`endif

      // Fill all four slots while the L2 is stalled
      l2_req_rdy = 1'b0;
      for (int i = 0; i < 4; i++)
         send_req(2'b01, 32'h0000_4000 + 32'(i * 64), 32'hC0DE_0000 + 32'(i), 8'(i));
      in_req_tag = 8'd4; in_req_val = 1'b1;
      @(negedge clk);
      chk("full_fifth_rdy", in_req_rdy, 0);
      chk("full_l2_req_val", l2_req_val, 1);
      @(posedge clk); #1;
      in_req_val = 1'b0;
      l2_req_rdy = 1'b1;
      wait_issue("fill_issue_order");

      // Free tag 0's slot, then nack tag 1 while accepting tag 9 in one cycle
      l2_respond(1'b0, 32'h0000_00A0, 8'd0, 1'b1);
      in_req_rw = 2'b01; in_req_addr = 32'h0000_9000; in_req_data = 32'h9999_0009;
      in_req_tag = 8'd9; in_req_val = 1'b1;
      l2_resp_val = 1'b1; l2_resp_nack = 1'b1; l2_resp_data = '0; l2_resp_tag = 8'd1;
      exp_req_q.push_back('{rw: 2'b01, addr: 32'h0000_4040, data: 32'hC0DE_0001, tag: 8'd1});
      exp_req_q.push_back('{rw: 2'b01, addr: 32'h0000_9000, data: 32'h9999_0009, tag: 8'd9});
      @(negedge clk);
      chk("simul_accept_rdy", in_req_rdy, 1);
      @(posedge clk); #1;
      in_req_val = 1'b0; l2_resp_val = 1'b0; l2_resp_nack = 1'b0;
      wait_issue("simul_issue_order");
      l2_respond(1'b0, 32'h0000_00A1, 8'd1, 1'b1);
      l2_respond(1'b0, 32'h0000_00A9, 8'd9, 1'b1);
      @(negedge clk);
      chk("no_err_before_reset", err_unmatched, 0);
`ifdef MEM_RETRY_STATS_EN
      chk("nack_count_3", nack_count, 3);
      chk("max_retries_keep2", max_retries, 2);
`endif
      @(posedge clk); #1;

      // Reset with tags 2 and 3 still outstanding
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_req_rdy", in_req_rdy, 0);
      chk("midrst_l2_req_val", l2_req_val, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      in_req_tag = 8'd2;
      l2_resp_val = 1'b1; l2_resp_nack = 1'b0; l2_resp_data = 32'h0000_00A2; l2_resp_tag = 8'd2;
      @(negedge clk);
      chk("stale_resp_dropped", in_resp_val, 0);
      chk("post_rst_rdy", in_req_rdy, 1);
      @(posedge clk); #1;
      l2_resp_val = 1'b0;
      @(negedge clk);
      chk("err_unmatched_set", err_unmatched, 1);
`ifdef MEM_RETRY_STATS_EN
      chk("nack_count_cleared", nack_count, 0);
      chk("max_retries_cleared", max_retries, 0);
`endif
      @(posedge clk); #1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("err_unmatched_sticky", err_unmatched, 1);
      chk("resp_queue_drained", exp_resp_q.size(), 0);
      chk("req_queue_drained", exp_req_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
